// File: rtl/min_uart_tx.sv
// min_uart_tx: byte FIFO that absorbs MIN framer bursts and serialises them as 8N1 UART.
// Define MIN_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module min_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [7:0]                  i_data,
    input  logic                        i_ovf_clr,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_empty,
    output logic                        o_full,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

`ifdef MIN_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_nxt;
    logic             push;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_wrap;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef MIN_UART_TX_PARITY_EN
    logic             parity;
`endif
    state_t           state;

    // Full is the registered flag, so a pop on the same edge never rescues a push.
    assign push      = i_wr && !o_full;
    assign drop      = i_wr && o_full;
    assign baud_wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign pop       = !o_empty && ((state == IDLE) || ((state == STOP) && baud_wrap));

    always_comb begin
        level_nxt = o_level;
        case ({push, pop})
            2'b10:   level_nxt = o_level + LVL_W'(1);
            2'b01:   level_nxt = o_level - LVL_W'(1);
            default: level_nxt = o_level;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            o_level <= level_nxt;
            o_empty <= (level_nxt == '0);
            o_full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
            if (drop)
                o_overflow <= 1'b1;
            else if (i_ovf_clr)
                o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (pop)
            shift <= mem[rd_ptr];
        else if ((state == DATA) && baud_wrap)
            shift <= {1'b0, shift[7:1]};
`ifdef MIN_UART_TX_PARITY_EN
        if (pop) parity <= ^mem[rd_ptr];
`endif
    end

    // o_tx is registered: each transition loads the level of the bit that follows it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
        end else begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    o_tx     <= 1'b1;
                    if (pop) begin
                        state  <= START;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        o_tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
`ifdef MIN_UART_TX_PARITY_EN
                            state <= PARITY;
                            o_tx  <= parity;
`else
                            state <= STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= shift[1];
                        end
                    end
                end
`ifdef MIN_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        if (pop) begin
                            state <= START;
                            o_tx  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            o_tx   <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_uart_tx.sv
// Bench for min_uart_tx: queue-based frame model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_min_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MIN_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       busy;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    bit chk_en = 1'b0;

    min_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(data), .i_ovf_clr(ovf_clr),
        .o_tx(tx), .o_busy(busy), .o_empty(empty), .o_full(full),
        .o_level(level), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame image: index 0 start, 1..8 data LSB first, then parity (if enabled) and stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef MIN_UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    logic [7:0]  m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_in_frame = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits = '1;

    initial forever begin
        bit full_b, empty_b, do_pop;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_in_frame = 1'b0;
            m_t = 0;
        end else begin
            full_b  = (m_q.size() == DEPTH);
            empty_b = (m_q.size() == 0);
            do_pop  = 1'b0;
            if (m_in_frame) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (!empty_b) begin
                        do_pop = 1'b1;
                        m_t = 0;
                    end else begin
                        m_in_frame = 1'b0;
                    end
                end
            end else if (!empty_b) begin
                do_pop = 1'b1;
                m_in_frame = 1'b1;
                m_t = 0;
            end
            if (do_pop) m_bits = frame_bits(m_q.pop_front());
            if (wr && !full_b) m_q.push_back(data);
            if (wr && full_b) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tx",       32'(tx),       32'(m_in_frame ? m_bits[m_t / CPB] : 1'b1));
            check("busy",     32'(busy),     32'(m_in_frame));
            check("level",    32'(level),    32'(m_q.size()));
            check("empty",    32'(empty),    32'(m_q.size() == 0));
            check("full",     32'(full),     32'(m_q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic send_check(input logic [7:0] b, input logic [10:0] exp);
        int s0;
        s0 = busy_cnt;
        wr = 1'b1;
        data = b;
        @(negedge clk);
        wr = 1'b0;
        check("push_empty", 32'(empty), 0);
        check("push_tx_idle", 32'(tx), 1);
        @(negedge clk);
        for (int j = 0; j < FB; j++) begin
            check($sformatf("bit%0d_of_%0h", j, b), 32'(tx), 32'(exp[j]));
            repeat (CPB) @(negedge clk);
        end
        check("frame_done_busy", 32'(busy), 0);
        check("frame_done_tx", 32'(tx), 1);
        check("frame_cycles", 32'(busy_cnt - s0), 32'(FRAME));
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < limit), 1);
    endtask

    initial begin
        int s0;
        int lows;
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int lows;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single frames with hand-computed line images.
`ifdef MIN_UART_TX_PARITY_EN
        send_check(8'hA5, 11'b10101001010);
`else
        send_check(8'hA5, 11'b11101001010);
`endif
        send_check(8'h01, 11'b11000000010);

        // Three consecutive pushes -> back-to-back frames.
        s0 = busy_cnt;
        wr = 1'b1; data = 8'h55;
        @(negedge clk); data = 8'hAA;
        check("b2b_level_k", 32'(level), 1);
        @(negedge clk); data = 8'h00;
        check("b2b_level_k1", 32'(level), 1);
        @(negedge clk); wr = 1'b0;
        check("b2b_level_k2", 32'(level), 2);
        repeat (FRAME - 2) @(negedge clk);
        check("b2b_level_pre_pop", 32'(level), 2);
        @(negedge clk);
        check("b2b_level_post_pop", 32'(level), 1);
        wait_idle(400);
        check("b2b_cycles", 32'(busy_cnt - s0), 32'(3 * FRAME));
        check("b2b_empty", 32'(empty), 1);

        // Overflow: six held pushes into a depth-4 FIFO.
        s0 = busy_cnt;
        wr = 1'b1; data = 8'h10;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            data = data + 8'h01;
            if (i == 5) begin
                check("ovf_full_at5", 32'(full), 1);
                check("ovf_level_at5", 32'(level), 4);
                check("ovf_not_yet", 32'(overflow), 0);
            end
        end
        wr = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_level_after_drop", 32'(level), 4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        wait_idle(600);
        check("ovf_five_frames", 32'(busy_cnt - s0), 32'(5 * FRAME));

        // Asynchronous reset mid-frame with three bytes queued.
        wr = 1'b1; data = 8'h31;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            data = data + 8'h01;
        end
        wr = 1'b0;
        check("rst_queued", 32'(level), 3);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 1);
        check("arst_busy", 32'(busy), 0);
        check("arst_level", 32'(level), 0);
        check("arst_empty", 32'(empty), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("arst_no_frame", 32'(lows), 0);
        check("arst_still_idle", 32'(busy), 0);

        // Clear coinciding with a dropped push: set wins.
        wr = 1'b1; data = 8'h41;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            data = data + 8'h01;
            if (i == 5) ovf_clr = 1'b1;
        end
        wr = 1'b0;
        ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared2", 32'(overflow), 0);
        wait_idle(600);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
